// File: rtl/single_cycle.sv
// Single-cycle LEGv8 core: fetch, decode, execute, memory and write-back all in one CLK period (CPI=1).
// MemtoRegOut is combinational from the current PC; no flow control, and resetl low aborts the instruction in flight.
module single_cycle (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  output logic [63:0] currentpc,
  output logic [63:0] MemtoRegOut
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_PASSB} alu_op_e;

  logic [63:0] pc_q, pc_d;
  logic [31:0] instr;
  logic        is_ldur, is_stur, is_add, is_sub, is_and, is_orr, is_cbz, is_b, is_movz;
  logic [4:0]  rn_addr, rm_addr, rd_addr;
  logic [63:0] rn_dat, rm_dat, alu_b, alu_res, mem_rd_dat, wb_dat;
  logic [63:0] imm9_sext, imm19_off, imm26_off, movz_val;
  logic        reg_wr, mem_wr;
  alu_op_e     alu_op;

  // Register file and data memory survive reset; their contents are fixed only at time zero.
  logic [63:0] rf_q   [32] = '{default: 64'h0};
  logic [63:0] dmem_q [32] = '{0: 64'h1, 1: 64'hA, 2: 64'h5, 3: 64'h0FFB_EA7D_EADB_EEFF, default: 64'h0};

  function automatic logic [31:0] imem_rd(input logic [61:0] idx);
    case (idx)
      62'd0:   imem_rd = 32'hF840_03E9;
      62'd1:   imem_rd = 32'hF840_83EA;
      62'd2:   imem_rd = 32'hF841_03EB;
      62'd3:   imem_rd = 32'hF841_83EC;
      62'd4:   imem_rd = 32'hF842_03ED;
      62'd5:   imem_rd = 32'hAA0B_014A;
      62'd6:   imem_rd = 32'h8A0A_018C;
      62'd7:   imem_rd = 32'hB400_0089;
      62'd8:   imem_rd = 32'h8B0C_01AD;
      62'd9:   imem_rd = 32'hCB09_0129;
      62'd10:  imem_rd = 32'h17FF_FFFD;
      62'd11:  imem_rd = 32'hF802_83ED;
      62'd12:  imem_rd = 32'hF842_83EA;
      62'd13:  imem_rd = 32'hD2E2_468B;
      62'd14:  imem_rd = 32'hD2CA_CF0C;
      62'd15:  imem_rd = 32'hAA0C_016B;
      62'd16:  imem_rd = 32'hD2B3_578C;
      62'd17:  imem_rd = 32'hAA0C_016B;
      62'd18:  imem_rd = 32'hD29B_DE0C;
      62'd19:  imem_rd = 32'hAA0C_016B;
      62'd20:  imem_rd = 32'hF803_03EB;
      62'd21:  imem_rd = 32'hF843_03ED;
      default: imem_rd = 32'h0;
    endcase
  endfunction

  // startpc is visible the instant reset asserts, not only once the flop has loaded it.
  assign currentpc = resetl ? pc_q : startpc;
  assign instr     = imem_rd(currentpc[63:2]);

  assign is_ldur = (instr[31:21] == 11'h7C2);
  assign is_stur = (instr[31:21] == 11'h7C0);
  assign is_add  = (instr[31:21] == 11'h458);
  assign is_sub  = (instr[31:21] == 11'h658);
  assign is_and  = (instr[31:21] == 11'h450);
  assign is_orr  = (instr[31:21] == 11'h550);
  assign is_cbz  = (instr[31:24] == 8'hB4);
  assign is_b    = (instr[31:26] == 6'h05);
  assign is_movz = (instr[31:23] == 9'h1A5);

  assign rd_addr = instr[4:0];
  assign rn_addr = instr[9:5];
  assign rm_addr = (is_stur || is_cbz) ? instr[4:0] : instr[20:16];
  assign rn_dat  = (rn_addr == 5'd31) ? 64'h0 : rf_q[rn_addr];
  assign rm_dat  = (rm_addr == 5'd31) ? 64'h0 : rf_q[rm_addr];

  assign imm9_sext = {{55{instr[20]}}, instr[20:12]};
  assign imm19_off = {{43{instr[23]}}, instr[23:5], 2'b00};
  assign imm26_off = {{36{instr[25]}}, instr[25:0], 2'b00};
  assign movz_val  = {48'h0, instr[20:5]} << {instr[22:21], 4'b0000};

  always_comb begin
    alu_op = ALU_PASSB;
    alu_b  = rm_dat;
    if (is_ldur || is_stur) begin
      alu_op = ALU_ADD;
      alu_b  = imm9_sext;
    end else if (is_add) begin
      alu_op = ALU_ADD;
    end else if (is_sub) begin
      alu_op = ALU_SUB;
    end else if (is_and) begin
      alu_op = ALU_AND;
    end else if (is_orr) begin
      alu_op = ALU_ORR;
    end else if (is_movz) begin
      alu_b  = movz_val;
    end
  end

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = rn_dat + alu_b;
      ALU_SUB: alu_res = rn_dat - alu_b;
      ALU_AND: alu_res = rn_dat & alu_b;
      ALU_ORR: alu_res = rn_dat | alu_b;
      default: alu_res = alu_b;
    endcase
  end

  assign mem_rd_dat  = dmem_q[alu_res[7:3]];
  assign wb_dat      = is_ldur ? mem_rd_dat : alu_res;
  assign MemtoRegOut = wb_dat;

  assign reg_wr = is_ldur || is_add || is_sub || is_and || is_orr || is_movz;
  assign mem_wr = is_stur;

  always_comb begin
    pc_d = currentpc + 64'd4;
    if (is_b) begin
      pc_d = currentpc + imm26_off;
    end else if (is_cbz && (rm_dat == 64'h0)) begin
      pc_d = currentpc + imm19_off;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc_q <= startpc;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Gating on resetl drops the commit of an instruction aborted by reset.
  always_ff @(posedge CLK) begin
    if (resetl && reg_wr && (rd_addr != 5'd31)) begin
      rf_q[rd_addr] <= wb_dat;
    end
  end

  always_ff @(posedge CLK) begin
    if (resetl && mem_wr) begin
      dmem_q[alu_res[7:3]] <= rm_dat;
    end
  end

endmodule

// File: tb/tb_single_cycle.sv
// Bench for single_cycle: an instruction-level model of the two programs runs alongside the core
// across deterministic and randomized reset/restart sequences.
module tb_single_cycle;

  logic        CLK;
  logic        resetl;
  logic [63:0] startpc;
  logic [63:0] currentpc;
  logic [63:0] MemtoRegOut;

  int n_chk = 0;
  int n_err = 0;

  single_cycle dut (
    .CLK         (CLK),
    .resetl      (resetl),
    .startpc     (startpc),
    .currentpc   (currentpc),
    .MemtoRegOut (MemtoRegOut)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef enum {M_NOP, M_LDUR, M_STUR, M_ADD, M_SUB, M_AND, M_ORR, M_CBZ, M_B, M_MOVZ} mop_e;
  typedef struct {
    mop_e   op;
    int     rd;
    int     rn;
    int     rm;
    longint imm;
    int     hw;
  } minst_t;

  minst_t      prog [longint];
  logic [63:0] m_reg [32];
  logic [63:0] m_mem [32];
  logic [63:0] m_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic put(input longint a, input mop_e op, input int rd, input int rn, input int rm,
                     input longint imm, input int hw);
    minst_t e;
    e.op = op; e.rd = rd; e.rn = rn; e.rm = rm; e.imm = imm; e.hw = hw;
    prog[a] = e;
  endtask

  function automatic logic [63:0] rv(input int r);
    return (r == 31) ? 64'h0 : m_reg[r];
  endfunction

  // One instruction: check at negedge+1, then commit the model at the rising edge.
  task automatic step(input int mode);
    minst_t      ins;
    logic [63:0] a, b, wb, addr, npc;
    bit          wdef, rwr, mwr;
    #1;
    chk($sformatf("pc@%0h", m_pc), currentpc, m_pc);
    if (prog.exists(longint'(m_pc))) ins = prog[longint'(m_pc)];
    else begin
      ins.op = M_NOP; ins.rd = 0; ins.rn = 0; ins.rm = 0; ins.imm = 0; ins.hw = 0;
    end
    a = rv(ins.rn);
    b = rv(ins.rd);
    addr = a + 64'(ins.imm);
    npc = m_pc + 64'd4;
    wb = 64'h0; wdef = 1'b1; rwr = 1'b0; mwr = 1'b0;
    case (ins.op)
      M_LDUR: begin wb = m_mem[addr[7:3]]; rwr = 1'b1; end
      M_STUR: begin wb = addr; mwr = 1'b1; end
      M_ADD:  begin wb = a + rv(ins.rm); rwr = 1'b1; end
      M_SUB:  begin wb = a - rv(ins.rm); rwr = 1'b1; end
      M_AND:  begin wb = a & rv(ins.rm); rwr = 1'b1; end
      M_ORR:  begin wb = a | rv(ins.rm); rwr = 1'b1; end
      M_MOVZ: begin wb = 64'(ins.imm) << (16 * ins.hw); rwr = 1'b1; end
      M_CBZ:  begin wdef = 1'b0; if (b == 64'h0) npc = m_pc + 64'(ins.imm * 4); end
      M_B:    begin wdef = 1'b0; npc = m_pc + 64'(ins.imm * 4); end
      default: wdef = 1'b0;
    endcase
    if (wdef) chk($sformatf("wb@%0h", m_pc), MemtoRegOut, wb);
    if (mode == 1 && (m_pc == 64'h14 || m_pc == 64'h18 || m_pc == 64'h30))
      chk($sformatf("p1_const@%0h", m_pc), MemtoRegOut, 64'hF);
    if (mode >= 1 && (m_pc == 64'h4C || m_pc == 64'h54))
      chk($sformatf("p2_const@%0h", m_pc), MemtoRegOut, 64'h1234_5678_9ABC_DEF0);
    @(posedge CLK);
    if (rwr && ins.rd != 31) m_reg[ins.rd] = wb;
    if (mwr) m_mem[addr[7:3]] = b;
    m_pc = npc;
    @(negedge CLK);
  endtask

  // Called at a falling edge; asserts reset before the next rising edge, releases at a falling edge.
  task automatic do_reset(input logic [63:0] spc, input int hold, input bit chg, input logic [63:0] spc2);
    #2;
    startpc = spc;
    resetl  = 1'b0;
    #1;
    chk("rst_async", currentpc, spc);
    m_pc = spc;
    repeat (hold) begin
      @(negedge CLK); #1;
      chk("rst_hold", currentpc, m_pc);
    end
    if (chg) begin
      startpc = spc2;
      m_pc    = spc2;
      #1;
      chk("rst_follow", currentpc, spc2);
      @(negedge CLK); #1;
      chk("rst_hold2", currentpc, spc2);
    end
    @(negedge CLK);
    resetl = 1'b1;
  endtask

  initial begin
    logic [63:0] spc, spc2;
    resetl  = 1'b0;
    startpc = 64'h30;
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 64'h0;
      m_mem[i] = 64'h0;
    end
    m_mem[0] = 64'h1;
    m_mem[1] = 64'hA;
    m_mem[2] = 64'h5;
    m_mem[3] = 64'h0FFB_EA7D_EADB_EEFF;

    put(64'h00, M_LDUR,  9, 31,  0, 0,  0);
    put(64'h04, M_LDUR, 10, 31,  0, 8,  0);
    put(64'h08, M_LDUR, 11, 31,  0, 16, 0);
    put(64'h0C, M_LDUR, 12, 31,  0, 24, 0);
    put(64'h10, M_LDUR, 13, 31,  0, 32, 0);
    put(64'h14, M_ORR,  10, 10, 11, 0,  0);
    put(64'h18, M_AND,  12, 12, 10, 0,  0);
    put(64'h1C, M_CBZ,   9,  0,  0, 4,  0);
    put(64'h20, M_ADD,  13, 13, 12, 0,  0);
    put(64'h24, M_SUB,   9,  9,  9, 0,  0);
    put(64'h28, M_B,     0,  0,  0, -3, 0);
    put(64'h2C, M_STUR, 13, 31,  0, 64'h28, 0);
    put(64'h30, M_LDUR, 10, 31,  0, 64'h28, 0);
    put(64'h34, M_MOVZ, 11,  0,  0, 64'h1234, 3);
    put(64'h38, M_MOVZ, 12,  0,  0, 64'h5678, 2);
    put(64'h3C, M_ORR,  11, 11, 12, 0,  0);
    put(64'h40, M_MOVZ, 12,  0,  0, 64'h9ABC, 1);
    put(64'h44, M_ORR,  11, 11, 12, 0,  0);
    put(64'h48, M_MOVZ, 12,  0,  0, 64'hDEF0, 0);
    put(64'h4C, M_ORR,  11, 11, 12, 0,  0);
    put(64'h50, M_STUR, 11, 31,  0, 64'h30, 0);
    put(64'h54, M_LDUR, 13, 31,  0, 64'h30, 0);

    // Program 2 from a long reset at 0x30.
    @(negedge CLK);
    do_reset(64'h30, 4, 1'b0, 64'h0);
    repeat (12) step(2);

    // Program 1, aborted by reset while 0x20 executes, then rerun through program 2.
    do_reset(64'h0, 2, 1'b0, 64'h0);
    for (int i = 0; i < 40 && m_pc != 64'h20; i++) step(1);
    #1;
    chk("reach_0x20", currentpc, 64'h20);
    do_reset(64'h0, 2, 1'b0, 64'h0);
    repeat (24) step(1);

    // Random restart points, reset lengths and run lengths.
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 3))
        0:       spc = 64'h0;
        1:       spc = 64'h30;
        2:       spc = 64'(4 * $urandom_range(0, 23));
        default: spc = 64'(4 * $urandom_range(0, 200));
      endcase
      spc2 = 64'(4 * $urandom_range(0, 23));
      do_reset(spc, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), spc2);
      repeat ($urandom_range(1, 30)) step(0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
